// File: rtl/apb_pkg.sv
// Shared types and slave-select decode for the APB initiator of the AHB2APB bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } apb_state_e;

    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;
    localparam logic [2:0] PSEL_NONE = 3'b000;

    // Select field value 3 has no slave behind it.
    function automatic logic [2:0] decode_sel(input logic [1:0] field);
        logic [2:0] sel;
        case (field)
            2'd0:    sel = PSEL_S0;
            2'd1:    sel = PSEL_S1;
            2'd2:    sel = PSEL_S2;
            default: sel = PSEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational address decode from the 2-bit select field to a one-hot APB psel.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int SEL_LSB = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        psel,
    output logic              unmapped
);

    // Only the select field matters; the rest of the address is intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr;

    always_comb begin
        psel     = decode_sel(addr[SEL_LSB+1:SEL_LSB]);
        unmapped = (psel == PSEL_NONE);
    end

endmodule

// File: rtl/apb_master.sv
// APB initiator: accepts one command at a time, runs SETUP/ACCESS with wait states
// and a timeout, and returns a one-cycle response strobe.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [2:0]        psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready
);

    apb_state_e state, state_nxt;
    logic [2:0] dec_psel;
    logic [2:0] sel_q;
    logic       dec_unmapped;
    logic       accept;
    logic       timeout_hit;
    logic [7:0] wait_cnt;

    apb_addr_decoder #(
        .ADDR_W (ADDR_W),
        .SEL_LSB(SEL_LSB)
    ) u_dec (
        .addr    (cmd_addr),
        .psel    (dec_psel),
        .unmapped(dec_unmapped)
    );

    assign accept = cmd_valid && cmd_ready;
    // Counter holds the number of earlier stalled ACCESS cycles, so this cycle is the TIMEOUT-th.
    assign timeout_hit = !pready && (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_unmapped ? ERR : SETUP;
                end
            end
            SETUP:   state_nxt = ACCESS;
            ACCESS: begin
                if (pready || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = hresetn && (state == IDLE);
        psel      = PSEL_NONE;
        penable   = 1'b0;
        if (state == SETUP || state == ACCESS) begin
            psel = sel_q;
        end
        if (state == ACCESS) begin
            penable = 1'b1;
        end
    end

    // Command latch: paddr/pwrite/pwdata stay stable from SETUP until the next accept.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
            sel_q  <= PSEL_NONE;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwdata <= cmd_wdata;
            pwrite <= cmd_write;
            sel_q  <= dec_psel;
        end
    end

    // Response registers and wait counter; rsp_rdata/rsp_err persist between responses.
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        wait_cnt <= '0;
                        if (dec_unmapped) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= pwrite ? '0 : prdata;
                    end else if (timeout_hit) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
